// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 registers the (optionally inverted) operands and the control fields.
//   Stage 2 computes the result and registers out, ofl and z.
//   ofl_sticky accumulates the overflow of every delivered beat.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   a, b, cin, op         operands, carry-in, operation select
//   inv_a, inv_b, sign    operand inversion, signed/unsigned overflow rule
//   out_valid / out_ready result handshake
//   out, ofl, z           result, overflow, zero flag of the current result beat
//   ofl_sticky, clr_sticky accumulated overflow and its clear
// Optional feature (macro ALU_PIPE_CARRY_EN): adds cout (adder carry) and n (result msb).
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ofl,
    output logic             z,
    output logic             ofl_sticky,
    input  logic             clr_sticky
`ifdef ALU_PIPE_CARRY_EN
    ,
    output logic             cout,
    output logic             n
`endif
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned WP1 = WIDTH + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_RLL = 3'b110;

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_t_q, a_t_d;
    logic [WIDTH-1:0] b_t_q, b_t_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic             sign_q, sign_d;

    // Stage 2 state
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ofl_q, ofl_d;
    logic             z_q, z_d;
    logic             ofl_sticky_q, ofl_sticky_d;
`ifdef ALU_PIPE_CARRY_EN
    logic             cout_q, cout_d;
`endif

    // Handshake / stall control
    logic s2_adv, s1_adv, accept, s2_load, deliver;

    // Stage 2 combinational result
    logic [WIDTH:0]     sum_ext;
    logic [2*WIDTH-1:0] rot_dbl;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   res;
    logic               res_ofl;
    logic               res_cout;
    logic               ovf_s;

    // Stall chain: a stage may move when the stage after it can take its beat.
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        accept   = in_valid & s1_adv;
        s2_load  = s2_adv & s1_valid_q;
        deliver  = s2_valid_q & out_ready;
        in_ready = s1_adv;
    end

    // Stage 1 next state: capture transformed operands on accept, hold while stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_t_d      = a_t_q;
        b_t_d      = b_t_q;
        op_d       = op_q;
        cin_d      = cin_q;
        sign_d     = sign_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            a_t_d  = a ^ {WIDTH{inv_a}};
            b_t_d  = b ^ {WIDTH{inv_b}};
            op_d   = op;
            cin_d  = cin;
            sign_d = sign;
        end
    end

    // Stage 2 execute.
    always_comb begin
        sh       = b_t_q[SHW-1:0];
        sum_ext  = {1'b0, a_t_q} + {1'b0, b_t_q} + WP1'(cin_q);
        // Rotate = upper half of the doubled operand shifted left.
        rot_dbl  = {a_t_q, a_t_q} << sh;
        ovf_s    = (a_t_q[WIDTH-1] & b_t_q[WIDTH-1] & ~sum_ext[WIDTH-1])
                 | (~a_t_q[WIDTH-1] & ~b_t_q[WIDTH-1] & sum_ext[WIDTH-1]);
        res      = '0;
        res_ofl  = 1'b0;
        res_cout = 1'b0;
        case (op_q)
            OP_ADD: begin
                res      = sum_ext[WIDTH-1:0];
                res_cout = sum_ext[WIDTH];
                res_ofl  = sign_q ? ovf_s : sum_ext[WIDTH];
            end
            OP_OR:   res = a_t_q | b_t_q;
            OP_XOR:  res = a_t_q ^ b_t_q;
            OP_AND:  res = a_t_q & b_t_q;
            OP_SRA:  res = WIDTH'($signed(a_t_q) >>> sh);
            OP_SRL:  res = a_t_q >> sh;
            OP_RLL:  res = rot_dbl[2*WIDTH-1:WIDTH];
            default: res = a_t_q << sh;
        endcase
    end

    // Stage 2 next state and sticky overflow (set has priority over clear).
    always_comb begin
        s2_valid_d   = s2_valid_q;
        out_d        = out_q;
        ofl_d        = ofl_q;
        z_d          = z_q;
`ifdef ALU_PIPE_CARRY_EN
        cout_d       = cout_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            out_d  = res;
            ofl_d  = res_ofl;
            z_d    = ~|res;
`ifdef ALU_PIPE_CARRY_EN
            cout_d = res_cout;
`endif
        end
        ofl_sticky_d = (ofl_sticky_q & ~clr_sticky) | (deliver & ofl_q);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            a_t_q        <= '0;
            b_t_q        <= '0;
            op_q         <= '0;
            cin_q        <= 1'b0;
            sign_q       <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_q        <= '0;
            ofl_q        <= 1'b0;
            z_q          <= 1'b0;
            ofl_sticky_q <= 1'b0;
`ifdef ALU_PIPE_CARRY_EN
            cout_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            a_t_q        <= a_t_d;
            b_t_q        <= b_t_d;
            op_q         <= op_d;
            cin_q        <= cin_d;
            sign_q       <= sign_d;
            s2_valid_q   <= s2_valid_d;
            out_q        <= out_d;
            ofl_q        <= ofl_d;
            z_q          <= z_d;
            ofl_sticky_q <= ofl_sticky_d;
`ifdef ALU_PIPE_CARRY_EN
            cout_q       <= cout_d;
`endif
        end
    end

    assign out_valid  = s2_valid_q;
    assign out        = out_q;
    assign ofl        = ofl_q;
    assign z          = z_q;
    assign ofl_sticky = ofl_sticky_q;
`ifdef ALU_PIPE_CARRY_EN
    assign cout       = cout_q;
    assign n          = out_q[WIDTH-1];
`endif

    // res_cout only feeds the optional carry register.
`ifndef ALU_PIPE_CARRY_EN
    logic unused_cout;
    assign unused_cout = res_cout;
`endif

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle 16-bit combinational ALU.
- Supports any power-of-two WIDTH and the same eight operations.
- Adds valid/ready handshakes on input and output, registered flags, and a sticky overflow flag.
- Sits between operand fetch and writeback in the execute path.

Parameters:
- WIDTH, 16, datapath width; power of two, at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; bits [SHW-1:0] of the transformed B are the shift count.
- cin  in  1  adder carry-in.
- op  in  3  operation: 000 ADD, 001 OR, 010 XOR, 011 AND, 100 SRA, 101 SRL, 110 RLL, 111 SLL.
- inv_a  in  1  invert A before use.
- inv_b  in  1  invert B before use.
- sign  in  1  1 = signed overflow rule, 0 = unsigned.
- out_valid  out  1  result beat is present.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- ofl  out  1  overflow for the result beat.
- z  out  1  out == 0.
- ofl_sticky  out  1  accumulated overflow.
- clr_sticky  in  1  clear ofl_sticky.

Behaviour:
- Reset: when rst_n is 0 at a clock edge, the following are cleared: s1_valid, s2_valid, out, ofl, z and ofl_sticky. As a result out_valid=0. in_ready=1 in the cycle after reset. Any in-flight beats are discarded, with no partial output.
- Accept: a beat is accepted when in_valid & in_ready. Delivery happens when out_valid & out_ready.
- Stall equations: s2_adv = ~s2_valid | out_ready. s1_adv = ~s1_valid | s2_adv. in_ready = s1_adv, which is combinational from out_ready.
- Throughput is one beat per cycle when out_ready is held at 1.
- Stage 1 registers the following on accept:
  - a_t = a ^ {WIDTH{inv_a}}
  - b_t = b ^ {WIDTH{inv_b}}
  - op, cin and sign.
- Stage 1 is held while it is stalled.
- Stage 2 computes from the stage 1 registers and registers out, ofl and z when s2_adv & s1_valid.
  - When stage 2 is not held and s1_valid=0, s2_valid goes to 0.
- Latency: an accept in cycle N gives out_valid in cycle N+2 if there is no stall.
- Output stability: while out_valid & ~out_ready, out, ofl and z are held stable.
- Arithmetic:
  - ADD: {cout, sum} = a_t + b_t + cin, with a WIDTH+1-bit result. out = sum.
  - OR, XOR, AND: bitwise on a_t and b_t.
  - The shift count is b_t[SHW-1:0].
  - SRA shifts in copies of a_t[WIDTH-1]. SRL and SLL shift in zeros. RLL rotates left.
  - A shift count of 0 gives out = a_t.
- ofl:
  - ADD with sign=1: (a_t msb & b_t msb & ~sum msb) | (~a_t msb & ~b_t msb & sum msb).
  - ADD with sign=0: cout.
  - All non-ADD ops: ofl = 0.
- z = ~|out for every op, not only ADD.
- ofl_sticky:
  - Set on the cycle after a delivered beat with ofl=1.
  - Cleared when clr_sticky=1.
  - If set and clear occur in the same cycle, set wins.
  - It is not affected by stalls.
  - It is only cleared by reset or clr_sticky.
- Boundary: a beat delivered and a new beat entering stage 2 in the same cycle is a legal full-throughput case, with no bubble.

Optional Feature:
- Macro: ALU_PIPE_CARRY_EN.
- When defined, two extra outputs are added:
  - cout (out, 1): registered adder carry for the result beat; 0 for non-ADD ops.
  - n (out, 1): out[WIDTH-1].
  - Both reset to 0 and are held with out during stalls.
- When undefined, neither port exists and no carry register is built. All other behaviour is identical.

Test Plan:
- WIDTH=16, ADD, a=16'hFFFF, b=16'h0001, cin=0, sign=0 -> out=16'h0000, z=1, ofl=1 two cycles after accept; ofl_sticky=1 the cycle after delivery.
- WIDTH=16, ADD, a=16'h7FFF, b=16'h0001, sign=1 -> out=16'h8000, ofl=1, z=0. Then a=16'h0005, inv_b=1, b=16'h0005, cin=1 (subtract) -> out=0, z=1, ofl=0.
- WIDTH=32, shifts with a=32'h8000_0001:
  - SRA b=4 -> 32'hF800_0000
  - SRL b=4 -> 32'h0800_0000
  - RLL b=1 -> 32'h0000_0003
  - SLL b=31 -> 32'h8000_0000
  - b=32 -> count 0 -> out=a.
- Back-to-back stream of 8 ADDs with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full; no beat is lost or duplicated; out is stable during the stall; results are in order.
- Two beats in flight, then rst_n=0 for one cycle -> out_valid=0, ofl_sticky=0 and in_ready=1 next cycle; neither beat is ever delivered.
- ofl_sticky=1, then clr_sticky=1 in the same cycle as delivery of an overflowing beat -> ofl_sticky stays 1. clr_sticky alone -> ofl_sticky 0 next cycle.
